// File: rtl/hw_accel_pkg.sv
// rtl/hw_accel_pkg.sv - shared types and constants for the frame sequencer
package hw_accel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_XFER,
    ST_WAIT_DESC,
    ST_FLUSH,
    ST_DONE
  } sched_state_t;

  localparam logic [1:0] MODE_SOBEL  = 2'd0;
  localparam logic [1:0] MODE_DILATE = 2'd1;
  localparam logic [1:0] MODE_ERODE  = 2'd2;

  localparam logic [7:0] DEFAULT_THRESH = 8'd100;

endpackage

// File: rtl/hw_accel_frame_sched.sv
// rtl/hw_accel_frame_sched.sv - frame sequencer: config latch, chunked DMA pacing, flush reset
module hw_accel_frame_sched
  import hw_accel_pkg::*;
#(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int CHUNK_LEN    = 1920,
  parameter int FLUSH_CYCLES = 4,
  parameter int DESC_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [1:0]  mode_i,
  input  logic [7:0]  thresh_i,
  input  logic        beat_i,
  input  logic        desc_updated_i,
  output logic        wr_en_o,
  output logic        last_o,
  output logic [1:0]  mode_o,
  output logic [7:0]  thresh_o,
  output logic        accel_rst_o,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic        err_o,
  output logic [15:0] frame_cnt_o
);

  localparam int NUM_CHUNKS = (FRAME_WIDTH * FRAME_HEIGHT) / CHUNK_LEN;
  localparam int BEAT_W     = (CHUNK_LEN > 1) ? $clog2(CHUNK_LEN) : 1;
  localparam int CHUNK_W    = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int TO_W       = $clog2(DESC_TIMEOUT + 1);
  localparam int FLUSH_W    = $clog2(FLUSH_CYCLES + 1);

  localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(CHUNK_LEN - 1);
  localparam logic [CHUNK_W-1:0] CHUNK_LAST = CHUNK_W'(NUM_CHUNKS - 1);
  localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(DESC_TIMEOUT - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);

  sched_state_t state, next_state;

  logic [BEAT_W-1:0]  beat_cnt;
  logic [CHUNK_W-1:0] chunk_cnt;
  logic [TO_W-1:0]    to_cnt;
  logic [FLUSH_W-1:0] flush_cnt;
  logic               desc_pend;
  logic               frame_ok;

  logic start_take, abort_take, chunk_wrap, final_chunk, desc_take, to_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state  = state;
    start_take  = 1'b0;
    abort_take  = 1'b0;
    chunk_wrap  = 1'b0;
    final_chunk = 1'b0;
    desc_take   = 1'b0;
    to_hit      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          start_take = 1'b1;
          next_state = ST_XFER;
        end
      end
      ST_XFER: begin
        if (abort_i) begin
          abort_take = 1'b1;
          next_state = ST_FLUSH;
        end else if (beat_i && beat_cnt == BEAT_LAST) begin
          chunk_wrap = 1'b1;
          if (chunk_cnt == CHUNK_LAST) begin
            final_chunk = 1'b1;
            next_state  = ST_FLUSH;
          end else begin
            next_state = ST_WAIT_DESC;
          end
        end
      end
      ST_WAIT_DESC: begin
        // A completion already pending wins over a timeout on the same cycle.
        if (abort_i) begin
          abort_take = 1'b1;
          next_state = ST_FLUSH;
        end else if (desc_pend) begin
          desc_take  = 1'b1;
          next_state = ST_XFER;
        end else if (to_cnt == TO_LAST) begin
          to_hit     = 1'b1;
          next_state = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt == FLUSH_LAST) next_state = frame_ok ? ST_DONE : ST_IDLE;
      end
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  assign last_o = beat_i && (state == ST_XFER) && (beat_cnt == BEAT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt     <= '0;
      chunk_cnt    <= '0;
      to_cnt       <= '0;
      flush_cnt    <= '0;
      desc_pend    <= 1'b0;
      frame_ok     <= 1'b0;
      err_o        <= 1'b0;
      mode_o       <= MODE_SOBEL;
      thresh_o     <= DEFAULT_THRESH;
      frame_cnt_o  <= '0;
      wr_en_o      <= 1'b0;
      accel_rst_o  <= 1'b0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      if (start_take) begin
        beat_cnt  <= '0;
        chunk_cnt <= '0;
        desc_pend <= 1'b0;
        frame_ok  <= 1'b0;
        err_o     <= 1'b0;
        mode_o    <= mode_i;
        thresh_o  <= thresh_i;
      end else begin
        if (state == ST_XFER && beat_i && !abort_take)
          beat_cnt <= chunk_wrap ? '0 : beat_cnt + 1'b1;
        if (chunk_wrap)  chunk_cnt <= chunk_cnt + 1'b1;
        if (final_chunk) frame_ok  <= 1'b1;
        if (to_hit)      err_o     <= 1'b1;
        // Early completions during XFER are held until WAIT_DESC consumes them.
        if (state == ST_XFER || state == ST_WAIT_DESC)
          desc_pend <= (desc_pend && !desc_take) || (desc_updated_i && !abort_i);
      end

      to_cnt    <= (state == ST_WAIT_DESC && next_state == ST_WAIT_DESC) ? to_cnt + 1'b1 : '0;
      flush_cnt <= (state == ST_FLUSH) ? flush_cnt + 1'b1 : '0;

      if (state == ST_FLUSH && next_state == ST_DONE) frame_cnt_o <= frame_cnt_o + 1'b1;

      wr_en_o      <= (next_state == ST_XFER);
      accel_rst_o  <= (next_state == ST_FLUSH);
      busy_o       <= (next_state != ST_IDLE);
      frame_done_o <= (next_state == ST_DONE);
    end
  end

endmodule

// File: doc/hw_accel_frame_sched.md
# hw_accel_frame_sched

Frame-level sequencer for the grayscale Sobel/morphology accelerator datapath. It owns per-frame control: it latches accelerator configuration at frame start and gates output-FIFO draining into DMA write chunks. It paces chunks against DMA descriptor completion, generates `last`, and issues the post-frame accelerator flush reset. It sits in the `clk` domain between the synchronised register-file controls and the DMA-in/accelerator/DMA-out pipeline.

## Interface
- `FRAME_WIDTH`, 640, pixels per line
- `FRAME_HEIGHT`, 480, lines per frame
- `CHUNK_LEN`, 1920, output beats per DMA write descriptor; FRAME_WIDTH*FRAME_HEIGHT must be a multiple of it
- `FLUSH_CYCLES`, 4, width of the accelerator reset pulse after each frame
- `DESC_TIMEOUT`, 65535, max cycles waiting for descriptor completion
- Clock and reset: clock `clk`; reset `rst`, asynchronous, active-high.
- `clk  in  1  core clock`
- `rst  in  1  asynchronous active-high reset`
- `start_i  in  1  frame start pulse (already synchronised); ignored unless idle`
- `abort_i  in  1  abort current frame`
- `mode_i  in  2  accelerator mode: 0 Sobel, 1 Sobel+dilation, else Sobel+erosion`
- `thresh_i  in  8  Sobel threshold`
- `beat_i  in  1  one output beat accepted by DMA (wvalid & wready)`
- `desc_updated_i  in  1  DMA descriptor completion pulse`
- `wr_en_o  out  1  permission to drain output FIFO into DMA`
- `last_o  out  1  combinational: beat_i on final beat of chunk`
- `mode_o  out  2  latched mode, stable for the whole frame`
- `thresh_o  out  8  latched threshold, stable for the whole frame`
- `accel_rst_o  out  1  flush reset for accelerator and FIFOs`
- `busy_o  out  1  state != IDLE`
- `frame_done_o  out  1  one-cycle pulse on normal frame completion`
- `err_o  out  1  sticky descriptor timeout; cleared only by rst or next start_i`
- `frame_cnt_o  out  16  completed-frame count, wraps at 65535→0`

## Operation
- States are IDLE, XFER, WAIT_DESC, FLUSH and DONE.
- IDLE:
  - On `start_i`, latch `mode_i`/`thresh_i`, clear `err_o`, beat and chunk counters, and the descriptor-pending flag.
  - Then go to XFER.
- XFER:
  - `wr_en_o`=1. Each `beat_i` increments `beat_cnt` (width clog2(CHUNK_LEN)).
  - On the beat where `beat_cnt`==CHUNK_LEN-1, `beat_cnt` wraps to 0 and `chunk_cnt` increments.
  - If that was chunk NUM_CHUNKS-1 (NUM_CHUNKS = W*H/CHUNK_LEN), go to FLUSH; otherwise go to WAIT_DESC.
- WAIT_DESC:
  - `wr_en_o`=0. When the descriptor-pending flag is set, clear it and return to XFER.
  - The timeout counter counts cycles in this state. On reaching DESC_TIMEOUT, set `err_o` and go to FLUSH.
- Descriptor-pending flag: set by `desc_updated_i` in XFER or WAIT_DESC, so an early completion is not lost. It is cleared when consumed and on entry from IDLE.
- FLUSH: `accel_rst_o`=1 for exactly FLUSH_CYCLES cycles; then go to DONE if the frame completed normally, else go to IDLE.
- DONE: `frame_done_o`=1 and `frame_cnt_o` increments, for one cycle; then go to IDLE.
- `abort_i` in XFER or WAIT_DESC takes priority over `beat_i` and over descriptor events. It goes to FLUSH with no DONE and no count increment. In IDLE, FLUSH and DONE it is ignored.
- `start_i` outside IDLE is ignored.
- `beat_i` outside XFER is counted nowhere (protocol error; `wr_en_o` low prevents it).
- `last_o` = `beat_i` & XFER & (`beat_cnt`==CHUNK_LEN-1).

## Timing
- Reset values: state IDLE; `wr_en_o` 0, `accel_rst_o` 0, `busy_o` 0, `frame_done_o` 0, `err_o` 0; `frame_cnt_o` 0; `mode_o` 0; `thresh_o` 100; all counters 0.
- All outputs are registered except `last_o`.
- `start_i` at cycle t gives `wr_en_o`/`busy_o` high at t+1.
- The final chunk beat at t gives `wr_en_o` low at t+1 and `accel_rst_o` high over t+1..t+FLUSH_CYCLES.
  - `frame_done_o` pulses at t+FLUSH_CYCLES+1.
  - `busy_o` falls at t+FLUSH_CYCLES+2.
- `desc_updated_i` in WAIT_DESC at t gives `wr_en_o` high at t+2 (flag set at t+1).
- `abort_i` at t gives `wr_en_o` 0 and `accel_rst_o` 1 at t+1.

## Structure
- Shared package `hw_accel_pkg`:
  - state enum
  - mode encodings (MODE_SOBEL=0, MODE_DILATE=1, MODE_ERODE=2)
  - default threshold 100
- NUM_CHUNKS and counter widths are derived localparams.
- The module is single-level; no sub-module.

## Test plan
Use FRAME 8x4 and CHUNK_LEN 8 (NUM_CHUNKS 4), FLUSH_CYCLES 4, DESC_TIMEOUT 16 unless stated.
- Nominal frame: start, 32 beats, `desc_updated_i` after each of chunks 0–2 → `last_o` on beats 7/15/23/31, `accel_rst_o` 4 cycles, one `frame_done_o`, `frame_cnt_o`=1.
- Early descriptor: `desc_updated_i` during chunk 1 beats → WAIT_DESC exits after 1 cycle, no stall.
- Timeout: no `desc_updated_i` after chunk 0 → `err_o`=1 after 16 cycles, FLUSH, no `frame_done_o`, `frame_cnt_o` unchanged.
- Abort coincident with beat 5 of chunk 2 → beat not counted, `accel_rst_o` next cycle, return to IDLE; restart clears counters and `err_o`.
- Config latch: start with mode=1/thresh=50, change inputs mid-frame → `mode_o`=1, `thresh_o`=50 until next start.
- Async reset asserted mid-XFER → all outputs at reset values immediately, `start_i` during busy ignored.
